serial_tx_fsm: RTL and testbench

Bit-serial frame transmitter for the lab serial link: accepts a parallel word via a start strobe and drives it onto the single-bit line `w` as start bit, data bits LSB first, optional even-parity bit, and stop bit. Each bit is held for a programmable number of clock cycles. It sits at the sending end of the link, producing the `w` stream consumed by the Moore-style receiver/detector FSMs on the other end.

---
 rtl/serial_tx_fsm_pkg.sv | 23 ++
 rtl/serial_tx_fsm_bit_timer.sv | 32 +++
 rtl/serial_tx_fsm.sv | 102 ++++++++++
 tb/tb_serial_tx_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_fsm_pkg.sv
// Shared definitions for the serial link: state encodings, line levels and default bit timing.
// Used by the transmitter here and by the receiver-side FSMs.
package serial_tx_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int DEFAULT_CLKS_PER_BIT = 4;

  // A counter for 0..n-1 needs at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_fsm_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of a period.
// Output is combinational from the count; clr holds the count at 0 and takes no backpressure.
module bit_timer
  import serial_tx_fsm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic Resetn,
  input  logic clr,
  output logic tick
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_tx_fsm.sv
// Bit-serial frame transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Line goes low one edge after start is accepted; start is only sampled in IDLE and never queued.
module serial_tx_fsm
  import serial_tx_fsm_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              w,
  output logic              busy,
  output logic              done
);

  localparam int IW = cnt_width(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;
  logic              r_par;
  logic              r_done;
  logic              w_tick;
  logic              w_clr;

  // Timer is held at 0 in IDLE so every frame starts on a fresh bit period.
  assign w_clr = (r_state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .Resetn (Resetn),
    .clr    (w_clr),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = START;
      START:   if (w_tick) w_next = DATA;
      DATA: begin
        if (w_tick && (r_idx == LAST_IDX)) begin
          w_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_tick;
      if ((r_state == IDLE) && start) begin
        r_shift <= din;
        r_idx   <= '0;
        r_par   <= 1'b0;
      end else if ((r_state == DATA) && w_tick) begin
        r_par   <= r_par ^ r_shift[0];
        r_shift <= r_shift >> 1;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + ONE_IDX;
      end
    end
  end

  always_comb begin
    w    = LINE_IDLE;
    busy = 1'b1;
    done = r_done;
    case (r_state)
      IDLE:    busy = 1'b0;
      START:   w = START_BIT;
      DATA:    w = r_shift[0];
      PARITY:  w = r_par;
      STOP:    w = LINE_IDLE;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_fsm.sv
// Bench for serial_tx_fsm: three instances (default, no parity, one clock per bit) checked
// cycle by cycle against an expected line waveform built from the frame format.
module tb_serial_tx_fsm;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [7:0] din_v [3];
  wire  [2:0] w_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;

  int checks = 0;
  int failures = 0;
  int last_busy_cnt = 0;
  int cpb_t [3] = '{4, 4, 1};
  int pen_t [3] = '{1, 0, 1};
  bit exp_q [$];

  always #5 clk = ~clk;

  serial_tx_fsm #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_def (
    .clk(clk), .Resetn(Resetn), .start(start_v[0]), .din(din_v[0]),
    .w(w_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  serial_tx_fsm #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_nopar (
    .clk(clk), .Resetn(Resetn), .start(start_v[1]), .din(din_v[1]),
    .w(w_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  serial_tx_fsm #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_fast (
    .clk(clk), .Resetn(Resetn), .start(start_v[2]), .din(din_v[2]),
    .w(w_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Expected line level for every busy cycle of one frame.
  task automatic build_exp(input int idx, input logic [7:0] d);
    exp_q.delete();
    for (int c = 0; c < cpb_t[idx]; c++) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < cpb_t[idx]; c++) exp_q.push_back(d[b]);
    if (pen_t[idx] != 0)
      for (int c = 0; c < cpb_t[idx]; c++) exp_q.push_back(($countones(d) % 2) == 1);
    for (int c = 0; c < cpb_t[idx]; c++) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input int idx, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (w_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) begin
        failures++;
        $display("FAIL %s idx=%0d cyc=%0d w/busy/done got=%b%b%b exp=100",
                 name, idx, i, w_v[idx], busy_v[idx], done_v[idx]);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_frame(input int idx, input logic [7:0] d, input bit hold,
                           input bit disturb, input string name);
    int busy_cnt;
    busy_cnt = 0;
    build_exp(idx, d);
    start_v[idx] = 1'b1;
    din_v[idx] = d;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (!hold) start_v[idx] = 1'b0;
      if (disturb && i == cpb_t[idx] * 3) begin
        start_v[idx] = 1'b1;
        din_v[idx] = ~d;
      end
      if (disturb && i == cpb_t[idx] * 3 + 1) start_v[idx] = 1'b0;
      if (busy_v[idx] === 1'b1) busy_cnt++;
      checks++;
      if (w_v[idx] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s line idx=%0d cyc=%0d got=%b exp=%b", name, idx, i, w_v[idx], exp_q[i]);
      end
      checks++;
      if (busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) begin
        failures++;
        $display("FAIL %s busy/done idx=%0d cyc=%0d got=%b%b exp=10",
                 name, idx, i, busy_v[idx], done_v[idx]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0 || w_v[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s done_cycle idx=%0d w/busy/done got=%b%b%b exp=101",
               name, idx, w_v[idx], busy_v[idx], done_v[idx]);
    end
    last_busy_cnt = busy_cnt;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (w_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values idx=%0d got=%b%b%b exp=100", k, w_v[k], busy_v[k], done_v[k]);
      end
    end
    Resetn = 1'b1;
    for (int k = 0; k < 3; k++) check_idle(k, (k == 0) ? 10 : 2, "idle_after_reset");
  endtask

  task automatic test_frame_a5();
    run_frame(0, 8'hA5, 1'b0, 1'b0, "frame_a5");
    checks++;
    if (last_busy_cnt != 44) begin
      failures++;
      $display("FAIL busy_len_a5 got=%0d exp=44", last_busy_cnt);
    end
    check_idle(0, 2, "after_a5");
  endtask

  task automatic test_parity_07();
    build_exp(0, 8'h07);
    checks++;
    if (exp_q[36] !== 1'b1) begin
      failures++;
      $display("FAIL model_parity_07 got=%b exp=1", exp_q[36]);
    end
    run_frame(0, 8'h07, 1'b0, 1'b0, "parity_07");
  endtask

  task automatic test_no_parity();
    run_frame(1, 8'h07, 1'b0, 1'b0, "nopar_07");
    checks++;
    if (last_busy_cnt != 40) begin
      failures++;
      $display("FAIL busy_len_nopar got=%0d exp=40", last_busy_cnt);
    end
    run_frame(1, 8'($urandom), 1'b0, 1'b0, "nopar_rand");
  endtask

  task automatic test_ignored_inputs();
    run_frame(0, 8'h5B, 1'b0, 1'b1, "ignored_start_din");
    check_idle(0, 6, "no_second_frame");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'h3C, 1'b1, 1'b0, "b2b_first");
    run_frame(0, 8'hC3, 1'b0, 1'b0, "b2b_second");
    check_idle(0, 3, "b2b_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int idx;
      idx = $urandom_range(0, 2);
      run_frame(idx, 8'($urandom), 1'b0, 1'b0, "random");
      check_idle(idx, $urandom_range(1, 3), "random_gap");
    end
  endtask

  task automatic test_async_reset();
    start_v[0] = 1'b1;
    din_v[0] = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (w_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_start got=%b%b%b exp=100", w_v[0], busy_v[0], done_v[0]);
    end
    @(negedge clk);
    Resetn = 1'b1;
    check_idle(0, 8, "no_done_after_abort");
  endtask

  task automatic test_fast_reset();
    run_frame(2, 8'hFF, 1'b0, 1'b0, "fast_ff");
    checks++;
    if (last_busy_cnt != 11) begin
      failures++;
      $display("FAIL busy_len_fast got=%0d exp=11", last_busy_cnt);
    end
    build_exp(2, 8'hFF);
    start_v[2] = 1'b1;
    din_v[2] = 8'hFF;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_v[2] = 1'b0;
      checks++;
      if (w_v[2] !== exp_q[i] || busy_v[2] !== 1'b1) begin
        failures++;
        $display("FAIL fast_pre_reset cyc=%0d w/busy got=%b%b exp=%b1", i, w_v[2], busy_v[2], exp_q[i]);
      end
    end
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (w_v[2] !== 1'b1 || busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
      failures++;
      $display("FAIL fast_async_reset got=%b%b%b exp=100", w_v[2], busy_v[2], done_v[2]);
    end
    @(negedge clk);
    Resetn = 1'b1;
    check_idle(2, 6, "fast_no_done");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) din_v[k] = 8'h00;
    test_reset();
    test_frame_a5();
    test_parity_07();
    test_no_parity();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_fast_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
